gomoku_line_fetch: RTL and testbench



---
 rtl/gomoku_pkg.sv | 32 +++
 rtl/gomoku_cell_addr.sv | 39 +++
 rtl/gomoku_line_fetch.sv | 161 ++++++++++++++++
 tb/tb_gomoku_line_fetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gomoku_pkg.sv
// Shared board constants, cell encodings and line-direction deltas for the gomoku
// move-evaluation pipeline.
package gomoku_pkg;

  localparam int BOARD_N    = 15;
  localparam int WIN_LEN    = 9;
  localparam int WIN_CENTRE = 4;
  localparam int NUM_DIR    = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [1:0] {
    DIR_HORIZ = 2'd0,
    DIR_VERT  = 2'd1,
    DIR_DIAG  = 2'd2,
    DIR_ANTI  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Row/column step per direction, indexed by dir_t.
  localparam logic signed [1:0] DIR_DR [NUM_DIR] = '{2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam logic signed [1:0] DIR_DC [NUM_DIR] = '{2'sd1, 2'sd0, 2'sd1, -2'sd1};

endpackage

// File: rtl/gomoku_cell_addr.sv
// Combinational target-cell locator: base cell plus offset along one line direction,
// returning whether the target lies on the board and its row-major RAM address.
module gomoku_cell_addr
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = 15,
  parameter int ADDR_W  = 8
) (
  input  logic [3:0]        base_row,
  input  logic [3:0]        base_col,
  input  logic [1:0]        dir,
  input  logic signed [3:0] offset,
  output logic              on_board,
  output logic [ADDR_W-1:0] addr
);

  logic signed [5:0] off6;
  logic signed [5:0] dr6;
  logic signed [5:0] dc6;
  logic signed [5:0] tgt_row;
  logic signed [5:0] tgt_col;
  logic              row_ok;
  logic              col_ok;

  assign off6 = {{2{offset[3]}}, offset};
  assign dr6  = {{4{DIR_DR[dir][1]}}, DIR_DR[dir]};
  assign dc6  = {{4{DIR_DC[dir][1]}}, DIR_DC[dir]};

  assign tgt_row = $signed({2'b00, base_row}) + off6 * dr6;
  assign tgt_col = $signed({2'b00, base_col}) + off6 * dc6;

  // Sign bit catches negatives; the magnitude compare catches the far edge.
  assign row_ok   = !tgt_row[5] && (tgt_row[4:0] < 5'(BOARD_N));
  assign col_ok   = !tgt_col[5] && (tgt_col[4:0] < 5'(BOARD_N));
  assign on_board = row_ok && col_ok;

  assign addr = ADDR_W'(tgt_row[4:0]) * ADDR_W'(BOARD_N) + ADDR_W'(tgt_col[4:0]);

endmodule

// File: rtl/gomoku_line_fetch.sv
// Walks the four 9-cell lines through a candidate move, one board-RAM cell per clock,
// and presents the resulting my/op windows through a valid/ready handshake.
module gomoku_line_fetch
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = 15,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_row,
  input  logic [3:0]        req_col,
  input  logic              req_side,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [35:0]       out_my,
  output logic [35:0]       out_op,
  output logic              out_err
);

  state_t      state_reg;
  logic [3:0]  row_reg;
  logic [3:0]  col_reg;
  logic        side_reg;
  logic        err_reg;
  logic [1:0]  dir_reg;
  logic [3:0]  idx_reg;
  logic        pend_valid_reg;
  logic [1:0]  pend_dir_reg;
  logic [3:0]  pend_idx_reg;
  logic [35:0] my_reg;
  logic [35:0] op_reg;
  logic        out_err_reg;
  logic        req_ready_reg;
  logic        out_valid_reg;

  logic signed [3:0]  offset;
  logic               on_board;
  logic [ADDR_W-1:0]  cell_addr;
  logic               is_centre;
  logic               rd_go;
  logic               last_step;
  logic [5:0]         cur_bit;
  logic [5:0]         pend_bit;
  logic [1:0]         my_cell;
  logic               pend_my;
  logic               pend_op;

  assign offset = $signed(idx_reg - 4'(WIN_CENTRE));

  gomoku_cell_addr #(
    .BOARD_N(BOARD_N),
    .ADDR_W (ADDR_W)
  ) u_cell_addr (
    .base_row(row_reg),
    .base_col(col_reg),
    .dir     (dir_reg),
    .offset  (offset),
    .on_board(on_board),
    .addr    (cell_addr)
  );

  assign is_centre = (idx_reg == 4'(WIN_CENTRE));
  assign rd_go     = (state_reg == FETCH) && !is_centre && on_board && !err_reg;
  assign last_step = (dir_reg == 2'(DIR_ANTI)) && (idx_reg == 4'(WIN_LEN - 1));

  assign mem_rd_en = rd_go;
  assign mem_addr  = rd_go ? cell_addr : '0;

  assign cur_bit  = 6'(dir_reg) * 6'(WIN_LEN) + 6'(idx_reg);
  assign pend_bit = 6'(pend_dir_reg) * 6'(WIN_LEN) + 6'(pend_idx_reg);

  // Reserved code 11 is treated as blocked, same as an opponent stone.
  assign my_cell = side_reg ? CELL_WHITE : CELL_BLACK;
  assign pend_my = pend_valid_reg && (mem_rd_data == my_cell);
  assign pend_op = pend_valid_reg && (mem_rd_data != my_cell) && (mem_rd_data != CELL_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      row_reg        <= '0;
      col_reg        <= '0;
      side_reg       <= 1'b0;
      err_reg        <= 1'b0;
      dir_reg        <= '0;
      idx_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_dir_reg   <= '0;
      pend_idx_reg   <= '0;
      my_reg         <= '0;
      op_reg         <= '0;
      out_err_reg    <= 1'b0;
      req_ready_reg  <= 1'b1;
      out_valid_reg  <= 1'b0;
    end else begin
      if (pend_my) my_reg[pend_bit] <= 1'b1;
      if (pend_op) op_reg[pend_bit] <= 1'b1;
      pend_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            row_reg       <= req_row;
            col_reg       <= req_col;
            side_reg      <= req_side;
            err_reg       <= (req_row >= 4'(BOARD_N)) || (req_col >= 4'(BOARD_N));
            dir_reg       <= '0;
            idx_reg       <= '0;
            my_reg        <= '0;
            op_reg        <= '0;
            out_err_reg   <= 1'b0;
            req_ready_reg <= 1'b0;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          pend_valid_reg <= rd_go;
          pend_dir_reg   <= dir_reg;
          pend_idx_reg   <= idx_reg;
          if (is_centre) begin
            my_reg[cur_bit] <= 1'b1;
          end else if (!rd_go) begin
            op_reg[cur_bit] <= 1'b1;
          end
          if (idx_reg == 4'(WIN_LEN - 1)) begin
            idx_reg <= '0;
            dir_reg <= dir_reg + 2'd1;
            if (last_step) state_reg <= DRAIN;
          end else begin
            idx_reg <= idx_reg + 4'd1;
          end
        end
        DRAIN: begin
          out_valid_reg <= 1'b1;
          out_err_reg   <= err_reg;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_my    = my_reg;
  assign out_op    = op_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_gomoku_line_fetch.sv
// Self-checking bench for gomoku_line_fetch: board RAM model with one-cycle read
// latency, expected windows queued per request and compared when out_valid rises.
module tb_gomoku_line_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_row;
  logic [3:0]  req_col;
  logic        req_side;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_rd_data = 2'b00;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_my;
  logic [35:0] out_op;
  logic        out_err;

  always #5 clk = ~clk;

  gomoku_line_fetch #(.BOARD_N(15), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_side   (req_side),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_my     (out_my),
    .out_op     (out_op),
    .out_err    (out_err)
  );

  logic [1:0] board [0:255];
  int read_cnt = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= board[mem_addr];
      read_cnt    <= read_cnt + 1;
    end
  end

  typedef struct {
    logic [35:0] my;
    logic [35:0] op;
    logic        err;
    int          reads;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic clear_board();
    for (int i = 0; i < 256; i++) board[i] = 2'b00;
  endtask

  // Reference model: walk each line with plain integer geometry.
  task automatic push_expected(input int row, input int col, input logic side);
    exp_t e;
    int r, c, o, dr, dc, b;
    logic [1:0] v, mine;
    e.my = '0; e.op = '0; e.reads = 0;
    e.err = (row > 14) || (col > 14);
    mine = side ? 2'b10 : 2'b01;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
      for (int k = 0; k < 9; k++) begin
        o = k - 4;
        r = row + o * dr;
        c = col + o * dc;
        b = 9 * d + k;
        if (k == 4) e.my[b] = 1'b1;
        else if (e.err || r < 0 || r > 14 || c < 0 || c > 14) e.op[b] = 1'b1;
        else begin
          e.reads++;
          v = board[r * 15 + c];
          if (v == mine) e.my[b] = 1'b1;
          else if (v != 2'b00) e.op[b] = 1'b1;
        end
      end
    end
    sb.push_back(e);
  endtask

  function automatic logic has_five(input logic [8:0] w);
    logic f = 1'b0;
    for (int i = 0; i <= 4; i++) if (w[i +: 5] == 5'h1F) f = 1'b1;
    return f;
  endfunction

  task automatic run_req(input int row, input int col, input logic side, input int hold, input string tag);
    int cycles, reads0;
    logic [35:0] my_s, op_s;
    logic err_s;
    logic frozen;
    exp_t e;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    end
    push_expected(row, col, side);
    req_valid = 1'b1; req_row = row[3:0]; req_col = col[3:0]; req_side = side;
    reads0 = read_cnt;
    @(negedge clk);
    cycles = 1;
    req_valid = 1'b0; req_row = ~req_row; req_col = ~req_col; req_side = ~side;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL %s req_ready_busy: got %b want 0", tag, req_ready);
    end
    while (out_valid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (cycles != 38) begin
      failures++; $display("FAIL %s latency: got %0d want 38", tag, cycles);
    end
    e = sb.pop_front();
    checks++;
    if (read_cnt - reads0 != e.reads) begin
      failures++; $display("FAIL %s reads: got %0d want %0d", tag, read_cnt - reads0, e.reads);
    end
    checks++;
    if (out_my !== e.my || out_op !== e.op || out_err !== e.err) begin
      failures++;
      $display("FAIL %s windows: got my=%h op=%h err=%b want my=%h op=%h err=%b",
               tag, out_my, out_op, out_err, e.my, e.op, e.err);
    end
    my_s = out_my; op_s = out_op; err_s = out_err;
    if (hold > 0) begin
      frozen = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || req_ready !== 1'b0 || mem_rd_en !== 1'b0 ||
            out_my !== my_s || out_op !== op_s || out_err !== err_s) frozen = 1'b0;
      end
      checks++;
      if (!frozen) begin
        failures++; $display("FAIL %s hold_frozen: got changed outputs want frozen for %0d cycles", tag, hold);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake: got out_valid=%b req_ready=%b want 0/1", tag, out_valid, req_ready);
    end
    $display("txn %s row=%0d col=%0d side=%0d my=%h op=%h err=%b latency=%0d reads=%0d",
             tag, row, col, side, out_my, out_op, out_err, cycles, read_cnt - reads0);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_row = '0; req_col = '0; req_side = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 8'h00 ||
        out_my !== 36'h0 || out_op !== 36'h0 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: got ready=%b valid=%b rd=%b addr=%h my=%h op=%h err=%b want 1/0/0/00/0/0/0",
               req_ready, out_valid, mem_rd_en, mem_addr, out_my, out_op, out_err);
    end
    rst = 1'b0;
    $display("txn reset ready=%b valid=%b", req_ready, out_valid);
  endtask

  task automatic test_centre();
    clear_board();
    run_req(7, 7, 1'b0, 0, "centre");
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (out_my[9*d +: 9] !== 9'h010 || out_op[9*d +: 9] !== 9'h000) begin
        failures++;
        $display("FAIL centre_win%0d: got my=%h op=%h want 010/000", d, out_my[9*d +: 9], out_op[9*d +: 9]);
      end
    end
  endtask

  task automatic test_corner();
    clear_board();
    run_req(0, 0, 1'b1, 0, "corner");
    checks++;
    if (out_op[8:0] !== 9'h00F || out_my[8:0] !== 9'h010) begin
      failures++; $display("FAIL corner_win0: got op=%h my=%h want 00F/010", out_op[8:0], out_my[8:0]);
    end
    checks++;
    if (out_op[35:27] !== 9'h1EF || out_my[35:27] !== 9'h010) begin
      failures++; $display("FAIL corner_win3: got op=%h my=%h want 1EF/010", out_op[35:27], out_my[35:27]);
    end
  endtask

  task automatic test_five();
    clear_board();
    for (int c = 3; c <= 6; c++) board[7 * 15 + c] = 2'b01;
    run_req(7, 7, 1'b0, 0, "five");
    checks++;
    if (out_my[8:0] !== 9'h01F || has_five(out_my[8:0]) !== 1'b1) begin
      failures++; $display("FAIL five_win0: got my=%h five=%b want 01F/1", out_my[8:0], has_five(out_my[8:0]));
    end
  endtask

  task automatic test_diag();
    clear_board();
    board[8 * 15 + 8] = 2'b10;
    run_req(7, 7, 1'b0, 0, "diag_black");
    checks++;
    if (out_op[26:18] !== 9'h020) begin
      failures++; $display("FAIL diag_black_op: got %h want 020", out_op[26:18]);
    end
    run_req(7, 7, 1'b1, 0, "diag_white");
    checks++;
    if (out_my[26:18] !== 9'h030 || out_op[26:18] !== 9'h000) begin
      failures++; $display("FAIL diag_white: got my=%h op=%h want 030/000", out_my[26:18], out_op[26:18]);
    end
  endtask

  task automatic test_out_of_range();
    int r0;
    clear_board();
    r0 = read_cnt;
    run_req(15, 2, 1'b0, 0, "oor");
    checks++;
    if (read_cnt != r0 || out_err !== 1'b1) begin
      failures++; $display("FAIL oor_reads_err: got reads=%0d err=%b want 0/1", read_cnt - r0, out_err);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (out_op[9*d +: 9] !== 9'h1EF || out_my[9*d +: 9] !== 9'h010) begin
        failures++;
        $display("FAIL oor_win%0d: got op=%h my=%h want 1EF/010", d, out_op[9*d +: 9], out_my[9*d +: 9]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_board();
    board[6 * 15 + 7] = 2'b11;
    board[7 * 15 + 9] = 2'b01;
    run_req(7, 7, 1'b0, 10, "hold10");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) board[i] = 2'($urandom_range(0, 3));
    run_req(3, 12, 1'b0, 0, "b2b_a");
    run_req(14, 14, 1'b1, 1, "b2b_b");
    for (int i = 0; i < 3; i++)
      run_req($urandom_range(0, 14), $urandom_range(0, 14), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), "random");
  endtask

  task automatic test_reset_mid_fetch();
    logic seen_valid;
    clear_board();
    @(negedge clk);
    req_valid = 1'b1; req_row = 4'd7; req_col = 4'd7; req_side = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || mem_rd_en !== 1'b0 || out_my !== 36'h0 || out_op !== 36'h0) begin
      failures++;
      $display("FAIL midreset_idle: got ready=%b valid=%b rd=%b my=%h op=%h want 1/0/0/0/0",
               req_ready, out_valid, mem_rd_en, out_my, out_op);
    end
    seen_valid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid === 1'b1 || mem_rd_en === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      failures++; $display("FAIL midreset_quiet: got activity after reset want none");
    end
    $display("txn midreset ready=%b valid=%b my=%h", req_ready, out_valid, out_my);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_board();
    test_reset();
    test_centre();
    test_corner();
    test_five();
    test_diag();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
